mux_rr_sel_arbiter: RTL
=======================

Name: mux_rr_sel_arbiter

Overview:
- Round-robin arbiter that shares one binary mux tree (mux2 … mux512 family) among N requesters.
- Drives the tree's SEL bus and a one-hot grant.
- Inserts programmable settle cycles after every SEL change, so the tree output is stable before a grant is issued.
- Bounds grant tenure with a hold limit; a long-running owner is preempted when another requester waits.

Parameters:
- N, 8, number of requesters; power of two, 2..512.
- SEL_W, 3, SEL width; must equal log2(N).
- SETTLE_CYC, 1, cycles SEL is held stable before a grant is issued; 0..15.
- MAX_HOLD, 16, maximum grant cycles while another request is pending; must be >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  per-requester request, level-sensitive.
- done  in  1  current owner finished; sampled only in GRANT.
- sel  out  SEL_W  registered mux-tree select.
- gnt  out  N  registered one-hot grant; all zero when not in GRANT.
- gnt_valid  out  1  high exactly when in GRANT.
- preempt  out  1  one-cycle pulse on a hold-limit release.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - state=IDLE, sel=0, gnt=0, gnt_valid=0, preempt=0.
  - Priority pointer ptr=0, hold_cnt=0, settle_cnt=0.
- States: IDLE, SETTLE, GRANT.
- IDLE:
  - If req != 0, winner = first index i scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 with req[i]=1.
  - sel<=winner at the next edge.
  - If SETTLE_CYC>0: go to SETTLE with settle_cnt<=SETTLE_CYC-1. Otherwise go to GRANT.
  - If req==0: stay in IDLE; sel holds its last value.
- SETTLE:
  - gnt=0 and sel stable.
  - If req[sel]=0: go to IDLE; ptr unchanged.
  - Else if settle_cnt==0: go to GRANT with hold_cnt<=0.
  - Else settle_cnt decrements.
- GRANT:
  - gnt[sel]=1 and gnt_valid=1.
  - Release condition A: done=1 or req[sel]=0.
  - Release condition B (preempt): hold_cnt==MAX_HOLD-1 and (req with bit sel masked) != 0; preempt pulses for 1 cycle at the transition edge.
  - On any release: go to IDLE, ptr<=(sel+1) mod N (wraps N-1 -> 0).
  - Otherwise hold_cnt increments, saturating at MAX_HOLD-1. A sole requester keeps the grant indefinitely.
  - A and B together: treated as A; no preempt pulse.
- Latency:
  - req rises in IDLE at edge k; sel updates at k+1; gnt/gnt_valid rise at k+1+SETTLE_CYC.
  - Every release passes through one IDLE cycle with gnt=0. Two consecutive grants are never adjacent or overlapping.
- Other rules:
  - gnt is never asserted while sel is changing.
  - sel changes only on the IDLE->SETTLE or IDLE->GRANT edge.
  - done outside GRANT is ignored.
  - Requests arriving during SETTLE or GRANT do not alter the current winner.
- Reset mid-operation: outputs drop to reset values immediately (asynchronous); ptr returns to 0.

Test Plan:
1. Single requester, SETTLE_CYC=1, N=8:
   - Stimulus: req=8'b0000_0100 at edge 0, done pulse 3 cycles after gnt rises.
   - Required: sel=2 at edge 1; gnt=0000_0100 and gnt_valid=1 from edge 2; IDLE one cycle after done; ptr=3.
2. Round-robin fairness:
   - Stimulus: req=8'hFF held; each owner asserts done 1 cycle after its grant.
   - Required: grant order 0,1,2,…,7,0 (wrap checked); one gnt=0 cycle between grants; preempt never asserts.
3. Preemption, MAX_HOLD=4:
   - Stimulus: req[1] held, no done; req[5] asserted 2 cycles into the grant.
   - Required: gnt[1] high exactly 4 cycles; preempt pulses once; sel=5 next; gnt[5] rises after 1 IDLE + SETTLE_CYC.
   - Control case: req[1] alone keeps the grant past 4 cycles with no preempt.
4. Request withdrawn during settle, SETTLE_CYC=3:
   - Stimulus: req[6] rises, then drops in the 2nd SETTLE cycle.
   - Required: state returns to IDLE; gnt stays 0 throughout; ptr unchanged (next req[6]|req[0] with ptr=0 grants 0).
5. Asynchronous reset mid-GRANT:
   - Stimulus: assert rst_n=0 between clock edges while gnt[4]=1.
   - Required: gnt=0, gnt_valid=0, sel=0 immediately without waiting for an edge; after release with req=8'h90, winner is 4.
6. Simultaneous release conditions:
   - Stimulus: done=1 on the same cycle as hold_cnt==MAX_HOLD-1 with another request pending.
   - Required: normal release with preempt=0; ptr=sel+1.

Source files
------------

// File: rtl/mux_rr_sel_arbiter_if.sv
// Handshake bundle between requesters and the mux-tree select arbiter.
// master = requester side, slave = arbiter side.
interface mux_rr_sel_arbiter_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = 3
);
  logic [N-1:0]     req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic             preempt;

  modport master (output req, output done,
                  input  sel, input gnt, input gnt_valid, input preempt);
  modport slave  (input  req, input done,
                  output sel, output gnt, output gnt_valid, output preempt);
endinterface

// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter driving a shared binary mux tree's SEL bus, with
// settle cycles after every SEL change and a bounded grant tenure.
module mux_rr_sel_arbiter #(
  parameter int unsigned N          = 8,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_rr_sel_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_INIT = (SETTLE_CYC == 0) ? '0 : CNT_W'(SETTLE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GRANT} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               preempt_q, preempt_d;

  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W-1:0]   scan_idx;
  logic [N-1:0]       sel_onehot;
  logic               owner_req;
  logic               others_req;

  // Scan downward from the farthest offset so the nearest request to ptr wins.
  always_comb begin
    win_idx  = ptr_q;
    scan_idx = ptr_q;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      scan_idx = ptr_q + SEL_W'(j);
      if (bus.req[scan_idx]) win_idx = scan_idx;
    end
  end

  assign sel_onehot = N'(1) << sel_q;
  assign owner_req  = bus.req[sel_q];
  assign others_req = |(bus.req & ~sel_onehot);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    settle_d    = settle_q;
    gnt_d       = '0;
    gnt_valid_d = 1'b0;
    preempt_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          sel_d = win_idx;
          if (SETTLE_CYC != 0) begin
            state_d  = S_SETTLE;
            settle_d = SETTLE_INIT;
          end else begin
            state_d     = S_GRANT;
            hold_d      = '0;
            gnt_d       = N'(1) << win_idx;
            gnt_valid_d = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (!owner_req) begin
          state_d = S_IDLE;
        end else if (settle_q == '0) begin
          state_d     = S_GRANT;
          hold_d      = '0;
          gnt_d       = sel_onehot;
          gnt_valid_d = 1'b1;
        end else begin
          settle_d = settle_q - CNT_W'(1);
        end
      end
      S_GRANT: begin
        // A normal release takes precedence over the hold-limit preempt.
        if (bus.done || !owner_req) begin
          state_d = S_IDLE;
          ptr_d   = sel_q + SEL_W'(1);
        end else if ((hold_q == HOLD_LAST) && others_req) begin
          state_d   = S_IDLE;
          ptr_d     = sel_q + SEL_W'(1);
          preempt_d = 1'b1;
        end else begin
          gnt_d       = sel_onehot;
          gnt_valid_d = 1'b1;
          if (hold_q != HOLD_LAST) hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      settle_q    <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      settle_q    <= settle_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.preempt   = preempt_q;

endmodule
